bcd_scan: RTL

BCD_SCAN -- requirements
Module: bcd_scan

---
 rtl/disp_pkg.sv | 26 ++
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 rtl/bcd_scan.sv | 139 +++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the BCD display path.
//   bcd_digit_t     : one packed BCD nibble
//   BCD_ADD3_THRESH : double-dabble correction threshold
//   conv_state_t    : converter FSM states
//   dec_max(n)      : largest value representable in n decimal digits (10**n-1)
package disp_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_t;

    function automatic int unsigned dec_max(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
//   clk, rst  : clock, async active-high reset
//   start_i   : begin conversion of bin_i (honoured only while idle)
//   bin_i     : binary value, must fit in N_DIGITS decimal digits
//   busy_o    : conversion in progress (registered)
//   done_c    : high during the cycle whose rising edge completes the conversion
//   bcd_c     : completed BCD vector, valid while done_c is high; digit 0 in bits [3:0]
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned BIN_W    = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [BIN_W-1:0]        bin_i,
    output logic                    busy_o,
    output logic                    done_c,
    output logic [4*N_DIGITS-1:0]   bcd_c
);

    localparam int unsigned BCD_W = 4 * N_DIGITS;
    localparam int unsigned CAT_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    conv_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic [BCD_W-1:0]   work_q,  work_d;
    logic               busy_q,  busy_d;

    logic [BCD_W-1:0]   adj_c;
    logic [CAT_W-1:0]   cat_c;
    logic               last_c;

    // Add 3 to every nibble >= 5 so the following shift carries correctly.
    always_comb begin
        bcd_digit_t nib;
        nib   = '0;
        adj_c = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            nib = work_q[4*i +: 4];
            if (nib >= BCD_ADD3_THRESH) begin
                nib = nib + 4'd3;
            end
            adj_c[4*i +: 4] = nib;
        end
    end

    assign cat_c  = {adj_c, bin_q} << 1;
    assign last_c = (cnt_q == CNT_W'(BIN_W - 1));
    assign bcd_c  = cat_c[CAT_W-1 -: BCD_W];
    assign done_c = (state_q == CONV_RUN) && last_c;
    assign busy_o = busy_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CONV_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        work_d  = work_q;
        case (state_q)
            CONV_IDLE: begin
                if (start_i) begin
                    state_d = CONV_RUN;
                    cnt_d   = '0;
                    bin_d   = bin_i;
                    work_d  = '0;
                end
            end
            CONV_RUN: begin
                work_d = cat_c[CAT_W-1 -: BCD_W];
                bin_d  = cat_c[BIN_W-1:0];
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_c) begin
                    state_d = CONV_IDLE;
                end
            end
            default: state_d = CONV_IDLE;
        endcase
        busy_d = (state_d == CONV_RUN);
    end

endmodule

// File: rtl/bcd_scan.sv
// Binary value to multiplexed BCD display driver.
// Accepts a binary value, clamps it to the displayable range, converts it to
// BCD, and scans the digits out one at a time for a 7-segment decoder.
//   clk, rst   : clock, async active-high reset
//   load       : convert bin_val (accepted only while busy=0)
//   bin_val    : unsigned value to display
//   busy       : conversion in progress
//   ovf        : last accepted value exceeded the displayable range
//   digit_num  : BCD digit of the active position
//   an         : active-low digit enables, one-hot-low
// Build option: define LEAD_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      bin_val,
    output logic                  busy,
    output logic                  ovf,
    output logic [3:0]            digit_num,
    output logic [N_DIGITS-1:0]   an
);

    localparam int unsigned   BCD_W   = 4 * N_DIGITS;
    localparam int unsigned   MAX_DEC = dec_max(N_DIGITS);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_DEC);
    localparam int unsigned   SCAN_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned   IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                  accept_c;
    logic                  over_c;
    logic [BIN_W-1:0]      conv_val_c;
    logic                  conv_busy;
    logic                  conv_done_c;
    logic [BCD_W-1:0]      conv_bcd_c;

    logic                  ovf_q,   ovf_d;
    logic [BCD_W-1:0]      disp_q,  disp_d;
    logic [SCAN_W-1:0]     scan_q,  scan_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [N_DIGITS-1:0]   an_q,    an_d;
    bcd_digit_t            digit_q, digit_d;

    // Out-of-range values are shown as all nines.
    assign over_c     = (bin_val > MAX_BIN);
    assign conv_val_c = over_c ? MAX_BIN : bin_val;
    assign accept_c   = load && !conv_busy;

    bin2bcd_seq #(
        .N_DIGITS (N_DIGITS),
        .BIN_W    (BIN_W)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept_c),
        .bin_i   (conv_val_c),
        .busy_o  (conv_busy),
        .done_c  (conv_done_c),
        .bcd_c   (conv_bcd_c)
    );

`ifdef LEAD_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] blank_c;

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_c    = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_q[4*i +: 4] == 4'd0);
            blank_c[i] = zero_above && (i != 0);
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= ~(N_DIGITS'(1));
            digit_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

    // Next-state logic: result capture, free-running scan, digit select
    always_comb begin
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        scan_d  = scan_q + SCAN_W'(1);
        idx_d   = idx_q;
        an_d    = '1;
        digit_d = '0;

        if (accept_c) begin
            ovf_d = over_c;
        end
        if (conv_done_c) begin
            disp_d = conv_bcd_c;
        end

        if (scan_q == SCAN_W'(REFRESH_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // Outputs are registered from the next index so they track idx_q exactly.
        for (int i = 0; i < N_DIGITS; i++) begin
            an_d[i] = (IDX_W'(i) != idx_d);
`ifdef LEAD_ZERO_BLANK_EN
            an_d[i] = an_d[i] | blank_c[i];
`endif
            if (IDX_W'(i) == idx_d) begin
                digit_d = disp_q[4*i +: 4];
            end
        end
    end

    assign busy      = conv_busy;
    assign ovf       = ovf_q;
    assign an        = an_q;
    assign digit_num = digit_q;

endmodule
